// File: rtl/mac_vector_pipe.sv
// Pipelined fixed-point dot-product engine: per-lane Q-format multiply, registered adder
// tree, and a multi-beat accumulator that emits one saturated result per dot product.
module mac_vector_pipe #(
  parameter int XLEN      = 16,
  parameter int FRAC      = 8,
  parameter int LANES     = 8,
  parameter int BEATS_MAX = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*XLEN-1:0] in_vec,
  input  logic [LANES*XLEN-1:0] in_weight,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_data,
  output logic                  out_sat,
  output logic                  out_overrun
);

  localparam int PW = 2 * XLEN;
  localparam int SW = PW + $clog2(LANES);
  localparam int AW = SW + $clog2(BEATS_MAX);
  localparam int CW = (BEATS_MAX > 1) ? $clog2(BEATS_MAX) : 1;

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-XLEN+1){1'b0}}, {(XLEN-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-XLEN+1){1'b1}}, {(XLEN-1){1'b0}}};

  function automatic logic signed [PW-1:0] sext(input logic [XLEN-1:0] x);
    return {{XLEN{x[XLEN-1]}}, x};
  endfunction

  logic advance;
  logic accept;
  logic cap;
  logic eff_last;
  logic beat_ovr;

  logic [CW-1:0] cnt;

  logic signed [PW-1:0] prod_c  [LANES];
  logic signed [PW-1:0] s1_prod [LANES];
  logic                 s1_valid, s1_last, s1_ovr;

  logic signed [SW-1:0] sum_c;
  logic signed [SW-1:0] s2_sum;
  logic                 s2_valid, s2_last, s2_ovr;

  logic signed [AW-1:0] acc;
  logic                 first;
  logic signed [AW-1:0] next_c;
  logic [XLEN-1:0]      sat_data_c;
  logic                 sat_flag_c;
  logic                 load;

  // One stall condition freezes every stage, bubbles included.
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  // Force-terminate the dot product on its BEATS_MAX-th beat.
  assign cap      = (cnt == CW'(BEATS_MAX - 1));
  assign eff_last = in_last || cap;
  assign beat_ovr = !in_last && cap;

  // NOTE: every variable driven in an always_comb gets a value on all paths (defaults or
  // a full loop), otherwise synthesis infers a latch to hold the missing case.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_c[i] = (sext(in_vec[i*XLEN +: XLEN]) * sext(in_weight[i*XLEN +: XLEN])) >>> FRAC;
    end
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_c = sum_c + SW'(s1_prod[i]);
    end
  end

  always_comb begin
    next_c     = (first ? '0 : acc) + AW'(s2_sum);
    sat_data_c = next_c[XLEN-1:0];
    sat_flag_c = 1'b0;
    if (next_c > SAT_MAX) begin
      sat_data_c = SAT_MAX[XLEN-1:0];
      sat_flag_c = 1'b1;
    end else if (next_c < SAT_MIN) begin
      sat_data_c = SAT_MIN[XLEN-1:0];
      sat_flag_c = 1'b1;
    end
  end

  assign load = s2_valid && advance && s2_last;

  // NOTE: lane data registers carry no reset; the valid flags alone qualify them, which
  // keeps the wide datapath free of reset routing.
  always_ff @(posedge clock) begin
    if (advance) begin
      s1_prod <= prod_c;
      s2_sum  <= sum_c;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values of the others regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      s1_ovr      <= 1'b0;
      s2_valid    <= 1'b0;
      s2_last     <= 1'b0;
      s2_ovr      <= 1'b0;
      acc         <= '0;
      first       <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sat     <= 1'b0;
      out_overrun <= 1'b0;
    end else begin
      if (accept) begin
        cnt <= eff_last ? '0 : cnt + 1'b1;
      end
      if (advance) begin
        s1_valid <= accept;
        s1_last  <= eff_last;
        s1_ovr   <= beat_ovr;
        s2_valid <= s1_valid;
        s2_last  <= s1_last;
        s2_ovr   <= s1_ovr;
        if (s2_valid) begin
          if (s2_last) begin
            first <= 1'b1;
          end else begin
            acc   <= next_c;
            first <= 1'b0;
          end
        end
      end
      if (load) begin
        out_valid   <= 1'b1;
        out_data    <= sat_data_c;
        out_sat     <= sat_flag_c;
        out_overrun <= s2_ovr;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mac_vector_pipe.md
Name: mac_vector_pipe

Overview:
- Parametrised, pipelined fixed-point dot-product engine for the LSTM gate datapath.
- Each accepted beat is LANES input elements times LANES weights, summed through a registered adder tree.
- Beats are accumulated until a beat marked last, then the block emits one saturated XLEN result.
- Valid/ready handshakes on input and output; backpressure stalls the whole pipeline.

Parameters:
- XLEN, 16: signed element width (two's complement).
- FRAC, 8: fractional bits of the Q format; each product is shifted right arithmetically by FRAC.
- LANES, 8: elements per beat; any integer ≥1, not required to be a power of two.
- BEATS_MAX, 16: maximum beats per dot product; must be ≥1.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat present.
- in_ready  out  1  block can accept a beat.
- in_vec  in  LANES*XLEN  input elements; lane i at bits [(i+1)*XLEN-1 : i*XLEN].
- in_weight  in  LANES*XLEN  weights, same packing as in_vec.
- in_last  in  1  beat is the final beat of the current dot product.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts the result.
- out_data  out  XLEN  saturated signed result.
- out_sat  out  1  result was clipped.
- out_overrun  out  1  the dot product was force-terminated at BEATS_MAX.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Pipeline valid bits, accumulator, beat counter, out_valid, out_data, out_sat and out_overrun clear to 0.
  - in_ready = 1 from the first cycle after release.
  - A dot product in flight is discarded; no partial result is ever emitted.
- Stall and handshake:
  - advance = !(out_valid && !out_ready).
  - in_ready = advance (combinational; no dependence on in_valid).
  - A beat is accepted when in_valid && in_ready at a rising edge.
  - When advance=0, all stage registers hold, including bubbles.
- Stage 1: for each lane, the signed product A*B (2*XLEN bits) is shifted right arithmetically by FRAC (floor) and registered at PW = 2*XLEN bits. The beat's valid and last flags are registered alongside.
- Stage 2: products are summed by a sign-extended adder tree, width SW = PW + clog2(LANES), with no overflow possible. The sum, valid and last are registered.
- Stage 3 (accumulate), when stage-2 valid && advance:
  - next = (first ? 0 : acc) + sum.
  - Accumulator width AW = SW + clog2(BEATS_MAX).
  - first is set at reset and after every last beat.
  - If last: out_data = sat(next), out_sat = clipped, out_overrun = the beat's overrun flag, out_valid = 1, first = 1.
  - Otherwise: acc = next.
- Saturation:
  - next > 2^(XLEN-1)-1 gives 2^(XLEN-1)-1 and out_sat=1.
  - next < -2^(XLEN-1) gives -2^(XLEN-1) and out_sat=1.
  - Otherwise the value is truncated to XLEN bits and out_sat=0.
- Latency: a beat accepted in cycle n that is last gives out_valid in cycle n+3, assuming no stalls.
- Throughput: one beat per cycle.
- The output register clears out_valid on out_ready unless a new result loads the same cycle; a back-to-back load is permitted.
- Beat counter counts accepted beats of the current dot product.
  - On the BEATS_MAX-th beat with in_last=0, the block treats the beat as last and tags it overrun; out_overrun=1 with that result.
  - The following beat starts a new dot product.
  - With BEATS_MAX=1, every beat is last.
- out_data, out_sat and out_overrun are stable while out_valid && !out_ready.

Test Plan:
- Reset and single-beat result: LANES=4, FRAC=8, all in_vec=256, all in_weight=256, in_last=1. Required: out_valid exactly 3 cycles after acceptance, out_data=1024, out_sat=0.
- Multi-beat accumulation: two beats of 256×256 with in_last on the second, then a new single beat of (-256)×256. Required: results 2048, then -1024; the accumulator restarts and the prior sum does not leak.
- Saturation: all lanes 0x7FFF×0x7FFF, 1 beat. Required: out_data=32767, out_sat=1. All lanes 0x8000×0x7FFF. Required: out_data=-32768, out_sat=1.
- Backpressure: hold out_ready=0 with a result pending and in_valid=1 streaming.
  - Required while held: in_ready=0 and outputs stable.
  - Then release out_ready for 1 cycle. Required: the next results arrive in order with no loss and no duplication.
- Overrun: BEATS_MAX=4, six beats of 256×256 (LANES=4) with in_last only on the sixth.
  - Required: first result 4096 with out_overrun=1.
  - Required: second result 2048 with out_overrun=0.
- Mid-operation reset: assert reset_n=0 after 2 beats of a 3-beat product, then release. Required: out_valid=0 and in_ready=1 after release. Then a fresh single beat of 256×256. Required: out_data=1024.
